pe_mem_port: RTL
================

# pe_mem_port

Data-memory access port for the RISC-V processing element. It sits directly downstream of the PE `controller`. It accepts that block's level-held `mem_read`/`mem_write` requests with a byte address, drives a simple request/grant/read-valid memory bus, and returns a one-cycle `mem_ack` with lane-aligned load data on `mem_Message`. Sign/zero extension remains in the PE ALU. This block only aligns the addressed byte, half or word to bit 0.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus-wait cycle limit. Only used with `PE_MEMPORT_TIMEOUT_EN`.

- `clk` input 1: clock. All state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `mem_read` input 1: load request from controller. Held high until `mem_ack`.
- `mem_write` input 1: store request. Held high until `mem_ack`.
- `mem_address` input 32: byte address (ALU result).
- `funct3` input 3: access size in `[1:0]` (00 byte, 01 half, 10 word). Bit 2 (unsigned) is ignored here.
- `wr_data` input 32: store data, right-aligned.
- `mem_ack` output 1: one-cycle completion pulse.
- `mem_Message` output 32: load data. Accessed lane is shifted to bit 0; upper bits are raw bus data.
- `mem_err` output 1: valid with `mem_ack`. Set for misaligned, illegal or timed-out accesses.
- `bus_req` output 1: bus request.
- `bus_we` output 1: 1 = write.
- `bus_addr` output 30: word address, `mem_address[31:2]`.
- `bus_be` output 4: byte enables.
- `bus_wdata` output 32: lane-replicated store data.
- `bus_gnt` input 1: bus accepted the request.
- `bus_rvalid` input 1: read data valid.
- `bus_rdata` input 32: read data word.

## Operation
- FSM states: IDLE, REQ, WAIT, ACK, HOLD. All outputs are registered (Moore).
- **IDLE**
  - Samples `mem_read`/`mem_write` on each edge.
  - On a request, latches address, size, `wr_data` and direction.
  - Legal request goes to REQ.
  - Misaligned request (half with `addr[0]`=1; word with `addr[1:0]`≠0), size 11, or `mem_read` and `mem_write` both high: goes to ACK with `mem_err`=1 and `mem_Message`=0. No bus traffic.
- **REQ**
  - `bus_req`=1; `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` stable until grant.
  - On `bus_gnt`: write goes to ACK; read goes to WAIT.
- **WAIT**
  - On `bus_rvalid`: `mem_Message` ← `bus_rdata >> (8*addr[1:0])`, go to ACK.
  - `bus_rvalid` is ignored in every other state.
- **ACK**
  - `mem_ack`=1 for exactly one cycle, with `mem_err` valid. Next state is HOLD.
- **HOLD**
  - Waits until `mem_read` and `mem_write` are both 0, then returns to IDLE.
  - Prevents a still-held request from being re-issued.
- **Byte enables** (`off` = `addr[1:0]`): byte `4'b0001<<off`; half `4'b0011<<off`; word `4'b1111`.
- **Write data:** byte `{4{wr_data[7:0]}}`; half `{2{wr_data[15:0]}}`; word `wr_data`.
- `mem_Message` and `mem_err` hold their values until the next accepted request.

## Timing
- **Reset:** state IDLE. `mem_ack`, `mem_err`, `bus_req`, `bus_we` are 0. `mem_Message`, `bus_addr`, `bus_be`, `bus_wdata` are 0.
- Reset asserted mid-transaction drops `bus_req` immediately (asynchronously). No `mem_ack` is produced.
- Request seen at edge N → `bus_req` high from N.
- Zero-wait-state timing:
  - Grant at edge N+1, `rvalid` at edge N+2 → `mem_ack` high in the cycle after N+2. Minimum read latency is 3 edges.
  - Minimum write latency is 2 edges.
  - Error path latency is 1 edge.
- The memory must assert `bus_rvalid` at least one cycle after `bus_gnt`.
- Back-to-back accesses require at least one cycle with the request low (HOLD).

## Configuration
- `PE_MEMPORT_TIMEOUT_EN` defined:
  - An 8+ bit counter runs in REQ and WAIT and clears on entry to REQ.
  - When it reaches `TIMEOUT_CYCLES`: drop `bus_req`, go to ACK with `mem_err`=1 and `mem_Message`=0.
- Not defined: no counter. REQ/WAIT wait indefinitely. `mem_err` covers only misaligned/illegal requests.

## Test plan
- Read word at 0x100, `bus_rdata`=0x12345678, gnt and rvalid with zero wait → `bus_be`=1111, `bus_addr`=0x40, `mem_Message`=0x12345678, `mem_ack` 3 edges after request, `mem_err`=0.
- Read byte at 0x103, `rdata`=0xAB000000 → `bus_be`=1000, `mem_Message[7:0]`=0xAB. Read half at 0x102 → `bus_be`=1100.
- Write byte 0x5A at 0x201 → `bus_we`=1, `bus_be`=0010, `bus_wdata`=0x5A5A5A5A, ack 2 edges after request. Request held 3 more cycles → exactly one bus transaction.
- Word read at 0x102 → `mem_ack` with `mem_err`=1, `bus_req` never asserted.
- With `PE_MEMPORT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `bus_gnt` tied 0 → `bus_req` drops, `mem_ack`/`mem_err`=1 after 4 wait cycles. Without the macro, still waiting at 100 cycles.
- Assert `rst` in WAIT → `bus_req`=0 immediately. After release: IDLE, no `mem_ack`. A new read completes normally.

Source files
------------

// File: rtl/pe_mem_port_if.sv
// Memory bus bundle between pe_mem_port (master) and data memory (slave).
// Signals: req/we/addr/be/wdata toward memory; gnt/rvalid/rdata back.
interface pe_mem_port_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/pe_mem_port.sv
// pe_mem_port: PE data-memory port. Turns level-held mem_read/mem_write
// from the controller into one req/gnt/rvalid bus transaction, returns
// a one-cycle mem_ack with lane-aligned load data and an error flag.
// Ports: clk, rst (async, active-high); mem_read, mem_write,
// mem_address, funct3, wr_data in; mem_ack, mem_Message, mem_err out;
// bus (pe_mem_port_if.master).
// Option: define PE_MEMPORT_TIMEOUT_EN to abort REQ/WAIT after
// TIMEOUT_CYCLES cycles with mem_err set.
module pe_mem_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   mem_address,
  input  logic [2:0]    funct3,
  input  logic [31:0]   wr_data,
  output logic          mem_ack,
  output logic [31:0]   mem_Message,
  output logic          mem_err,
  pe_mem_port_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  state_t      state_q;
  logic        mem_ack_q;
  logic        mem_err_q;
  logic [31:0] msg_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [29:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [1:0]  off_q;

  logic [1:0]  req_off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        bad_d;
  logic [31:0] rdata_sh;
  logic        tmo;

  assign req_off = mem_address[1:0];

  // Lane enables, replicated store data and legality of the request.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = wr_data;
    bad_d   = 1'b0;
    unique case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_off;
        wdata_d = {4{wr_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << req_off;
        wdata_d = {2{wr_data[15:0]}};
        bad_d   = req_off[0];
      end
      2'b10: begin
        be_d  = 4'b1111;
        bad_d = |req_off;
      end
      default: bad_d = 1'b1;
    endcase
    if (mem_read && mem_write) bad_d = 1'b1;
  end

  assign rdata_sh = bus.bus_rdata >> {off_q, 3'b000};

`ifdef PE_MEMPORT_TIMEOUT_EN
  localparam int CLW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CLW < 8) ? 8 : CLW;

  logic [CW-1:0] cnt_q;

  // Only REQ/WAIT count; REQ is always entered from IDLE, where the
  // counter sits at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  logic unused_cfg;
  assign unused_cfg = funct3[2];
`else
  assign tmo = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{funct3[2], TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_ack_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      msg_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
    end else begin
      mem_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            if (bad_d) begin
              state_q   <= S_ACK;
              mem_ack_q <= 1'b1;
              mem_err_q <= 1'b1;
              msg_q     <= '0;
            end else begin
              state_q     <= S_REQ;
              mem_err_q   <= 1'b0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_write;
              bus_addr_q  <= mem_address[31:2];
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              off_q       <= req_off;
            end
          end
        end
        S_REQ: begin
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            if (bus_we_q) begin
              state_q   <= S_ACK;
              mem_ack_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (tmo) begin
            bus_req_q <= 1'b0;
            state_q   <= S_ACK;
            mem_ack_q <= 1'b1;
            mem_err_q <= 1'b1;
            msg_q     <= '0;
          end
        end
        S_WAIT: begin
          if (bus.bus_rvalid) begin
            msg_q     <= rdata_sh;
            state_q   <= S_ACK;
            mem_ack_q <= 1'b1;
          end else if (tmo) begin
            state_q   <= S_ACK;
            mem_ack_q <= 1'b1;
            mem_err_q <= 1'b1;
            msg_q     <= '0;
          end
        end
        S_ACK: begin
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // Wait for the controller to drop a still-held request.
          if (!mem_read && !mem_write) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_ack       = mem_ack_q;
  assign mem_err       = mem_err_q;
  assign mem_Message   = msg_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule
